// File: rtl/deco_issue_seq.sv
// Issue sequencer: accepts instruction words, folds I/T prefixes into the next core op and
// issues one merged micro-op per core word, tracking fragment boundaries and protocol errors.

module deco_issue_seq_decoder #(
    parameter int IDX_W = 6
) (
    input  logic [31:0]      word,
    output logic [2:0]       op,
    output logic             end_f,
    output logic [IDX_W-1:0] nalloc,
    output logic [25:0]      immhi,
    output logic [15:0]      tgt
);
    assign op     = word[31:29];
    assign end_f  = word[28];
    assign nalloc = word[IDX_W-1:0];
    assign immhi  = word[25:0];
    assign tgt    = word[15:0];
endmodule

module deco_issue_seq #(
    parameter int IDX_W = 6,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_word,
    output logic             uop_valid,
    input  logic             uop_ready,
    output logic [31:0]      uop_word,
    output logic [IDX_W-1:0] uop_idx,
    output logic [25:0]      uop_immhi,
    output logic             uop_immhi_vld,
    output logic [15:0]      uop_tgt,
    output logic             uop_tgt_vld,
    output logic             frag_active,
    output logic [IDX_W-1:0] frag_nalloc,
    output logic             frag_done,
    output logic [CNT_W-1:0] frag_count,
    output logic             err,
    output logic [1:0]       err_code
);
    typedef enum logic [1:0] {IDLE = 2'd0, BODY = 2'd1, ISSUE = 2'd2} state_t;

    logic [2:0]       op_s;
    logic             end_f_s;
    logic [IDX_W-1:0] nalloc_s;
    logic [25:0]      immhi_s;
    logic [15:0]      tgt_s;
    logic             accept_s;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             uop_valid_q, uop_valid_d;
    logic [31:0]      uop_word_q, uop_word_d;
    logic [IDX_W-1:0] uop_idx_q, uop_idx_d;
    logic [25:0]      uop_immhi_q, uop_immhi_d;
    logic             uop_immhi_vld_q, uop_immhi_vld_d;
    logic [15:0]      uop_tgt_q, uop_tgt_d;
    logic             uop_tgt_vld_q, uop_tgt_vld_d;
    logic             frag_active_q, frag_active_d;
    logic [IDX_W-1:0] nalloc_q, nalloc_d;
    logic             frag_done_q, frag_done_d;
    logic [CNT_W-1:0] frag_count_q, frag_count_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             immhi_vld_q, immhi_vld_d;
    logic [25:0]      immhi_q, immhi_d;
    logic             tgt_vld_q, tgt_vld_d;
    logic [15:0]      tgt_q, tgt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    deco_issue_seq_decoder #(.IDX_W(IDX_W)) u_decoder (
        .word   (in_word),
        .op     (op_s),
        .end_f  (end_f_s),
        .nalloc (nalloc_s),
        .immhi  (immhi_s),
        .tgt    (tgt_s)
    );

    assign accept_s = in_valid && in_ready_q;

    // Next-state logic for the sequencer and all registered outputs
    always_comb begin
        state_d         = state_q;
        in_ready_d      = in_ready_q;
        uop_valid_d     = uop_valid_q;
        uop_word_d      = uop_word_q;
        uop_idx_d       = uop_idx_q;
        uop_immhi_d     = uop_immhi_q;
        uop_immhi_vld_d = uop_immhi_vld_q;
        uop_tgt_d       = uop_tgt_q;
        uop_tgt_vld_d   = uop_tgt_vld_q;
        frag_active_d   = frag_active_q;
        nalloc_d        = nalloc_q;
        frag_done_d     = 1'b0;
        frag_count_d    = frag_count_q;
        err_d           = 1'b0;
        err_code_d      = 2'd0;
        immhi_vld_d     = immhi_vld_q;
        immhi_d         = immhi_q;
        tgt_vld_d       = tgt_vld_q;
        tgt_d           = tgt_q;
        idx_d           = idx_q;
        cnt_d           = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    if ((op_s == 3'b101) && !end_f_s) begin
                        nalloc_d      = nalloc_s;
                        idx_d         = {IDX_W{1'b0}};
                        cnt_d         = {CNT_W{1'b0}};
                        immhi_vld_d   = 1'b0;
                        tgt_vld_d     = 1'b0;
                        frag_active_d = 1'b1;
                        state_d       = BODY;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = op_s[2] && op_s[1] ? 2'd3 : 2'd1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BODY: begin
                if (accept_s) begin
                    case (op_s)
                        3'b000, 3'b001, 3'b010: begin
                            uop_word_d      = in_word;
                            uop_idx_d       = idx_q;
                            uop_immhi_d     = immhi_q;
                            uop_immhi_vld_d = immhi_vld_q;
                            uop_tgt_d       = tgt_q;
                            uop_tgt_vld_d   = tgt_vld_q;
                            uop_valid_d     = 1'b1;
                            in_ready_d      = 1'b0;
                            state_d         = ISSUE;
                            // Over-allocation still issues, but is reported
                            if (idx_q >= nalloc_q) begin
                                err_d      = 1'b1;
                                err_code_d = 2'd1;
                            end else begin
                                err_d      = 1'b0;
                            end
                        end
                        3'b011: begin
                            tgt_d     = tgt_s;
                            tgt_vld_d = 1'b1;
                            if (tgt_vld_q) begin
                                err_d      = 1'b1;
                                err_code_d = 2'd2;
                            end else begin
                                err_d      = 1'b0;
                            end
                        end
                        3'b100: begin
                            immhi_d     = immhi_s;
                            immhi_vld_d = 1'b1;
                            if (immhi_vld_q) begin
                                err_d      = 1'b1;
                                err_code_d = 2'd2;
                            end else begin
                                err_d      = 1'b0;
                            end
                        end
                        3'b101: begin
                            frag_done_d  = 1'b1;
                            frag_count_d = cnt_q;
                            immhi_vld_d  = 1'b0;
                            tgt_vld_d    = 1'b0;
                            if (end_f_s) begin
                                frag_active_d = 1'b0;
                                state_d       = IDLE;
                                if (immhi_vld_q || tgt_vld_q) begin
                                    err_d      = 1'b1;
                                    err_code_d = 2'd2;
                                end else begin
                                    err_d      = 1'b0;
                                end
                            end else begin
                                // Nested start closes the open fragment and reopens
                                err_d      = 1'b1;
                                err_code_d = 2'd1;
                                nalloc_d   = nalloc_s;
                                idx_d      = {IDX_W{1'b0}};
                                cnt_d      = {CNT_W{1'b0}};
                            end
                        end
                        default: begin
                            err_d      = 1'b1;
                            err_code_d = 2'd3;
                        end
                    endcase
                end else begin
                    state_d = BODY;
                end
            end
            ISSUE: begin
                if (uop_ready) begin
                    uop_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    immhi_vld_d = 1'b0;
                    tgt_vld_d   = 1'b0;
                    idx_d       = (idx_q == {IDX_W{1'b1}}) ? idx_q : idx_q + 1'b1;
                    cnt_d       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
                    state_d     = BODY;
                end else begin
                    state_d = ISSUE;
                end
            end
            default: begin
                state_d       = IDLE;
                in_ready_d    = 1'b1;
                uop_valid_d   = 1'b0;
                frag_active_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            in_ready_q      <= 1'b1;
            uop_valid_q     <= 1'b0;
            uop_word_q      <= 32'd0;
            uop_idx_q       <= {IDX_W{1'b0}};
            uop_immhi_q     <= 26'd0;
            uop_immhi_vld_q <= 1'b0;
            uop_tgt_q       <= 16'd0;
            uop_tgt_vld_q   <= 1'b0;
            frag_active_q   <= 1'b0;
            nalloc_q        <= {IDX_W{1'b0}};
            frag_done_q     <= 1'b0;
            frag_count_q    <= {CNT_W{1'b0}};
            err_q           <= 1'b0;
            err_code_q      <= 2'd0;
            immhi_vld_q     <= 1'b0;
            immhi_q         <= 26'd0;
            tgt_vld_q       <= 1'b0;
            tgt_q           <= 16'd0;
            idx_q           <= {IDX_W{1'b0}};
            cnt_q           <= {CNT_W{1'b0}};
        end else begin
            state_q         <= state_d;
            in_ready_q      <= in_ready_d;
            uop_valid_q     <= uop_valid_d;
            uop_word_q      <= uop_word_d;
            uop_idx_q       <= uop_idx_d;
            uop_immhi_q     <= uop_immhi_d;
            uop_immhi_vld_q <= uop_immhi_vld_d;
            uop_tgt_q       <= uop_tgt_d;
            uop_tgt_vld_q   <= uop_tgt_vld_d;
            frag_active_q   <= frag_active_d;
            nalloc_q        <= nalloc_d;
            frag_done_q     <= frag_done_d;
            frag_count_q    <= frag_count_d;
            err_q           <= err_d;
            err_code_q      <= err_code_d;
            immhi_vld_q     <= immhi_vld_d;
            immhi_q         <= immhi_d;
            tgt_vld_q       <= tgt_vld_d;
            tgt_q           <= tgt_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign uop_valid     = uop_valid_q;
    assign uop_word      = uop_word_q;
    assign uop_idx       = uop_idx_q;
    assign uop_immhi     = uop_immhi_q;
    assign uop_immhi_vld = uop_immhi_vld_q;
    assign uop_tgt       = uop_tgt_q;
    assign uop_tgt_vld   = uop_tgt_vld_q;
    assign frag_active   = frag_active_q;
    assign frag_nalloc   = nalloc_q;
    assign frag_done     = frag_done_q;
    assign frag_count    = frag_count_q;
    assign err           = err_q;
    assign err_code      = err_code_q;
endmodule

// File: tb/tb_deco_issue_seq.sv
// Directed self-checking bench for deco_issue_seq with hand-computed expectations.

module tb_deco_issue_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        uop_valid;
    logic        uop_ready;
    logic [31:0] uop_word;
    logic [5:0]  uop_idx;
    logic [25:0] uop_immhi;
    logic        uop_immhi_vld;
    logic [15:0] uop_tgt;
    logic        uop_tgt_vld;
    logic        frag_active;
    logic [5:0]  frag_nalloc;
    logic        frag_done;
    logic [6:0]  frag_count;
    logic        err;
    logic [1:0]  err_code;

    int total = 0;
    int bad   = 0;

    deco_issue_seq #(.IDX_W(6), .CNT_W(7)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_word       (in_word),
        .uop_valid     (uop_valid),
        .uop_ready     (uop_ready),
        .uop_word      (uop_word),
        .uop_idx       (uop_idx),
        .uop_immhi     (uop_immhi),
        .uop_immhi_vld (uop_immhi_vld),
        .uop_tgt       (uop_tgt),
        .uop_tgt_vld   (uop_tgt_vld),
        .frag_active   (frag_active),
        .frag_nalloc   (frag_nalloc),
        .frag_done     (frag_done),
        .frag_count    (frag_count),
        .err           (err),
        .err_code      (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        in_valid = 1'b1;
        in_word  = w;
        tick();
        in_valid = 1'b0;
        in_word  = 32'd0;
    endtask

    initial begin
        logic [31:0] held;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_word   = 32'd0;
        uop_ready = 1'b0;
        #23;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_uop_valid", {31'd0, uop_valid}, 32'd0);
        chk("rst_frag_active", {31'd0, frag_active}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic fragment: start, ALU, end
        uop_ready = 1'b1;
        send(32'hA000_0003);
        chk("t2_active", {31'd0, frag_active}, 32'd1);
        chk("t2_nalloc", {26'd0, frag_nalloc}, 32'd3);
        send(32'h0000_0001);
        chk("t2_uop_valid", {31'd0, uop_valid}, 32'd1);
        chk("t2_uop_idx", {26'd0, uop_idx}, 32'd0);
        chk("t2_immhi_vld", {31'd0, uop_immhi_vld}, 32'd0);
        chk("t2_uop_word", uop_word, 32'h0000_0001);
        chk("t2_in_ready_issue", {31'd0, in_ready}, 32'd0);
        tick();
        chk("t2_uop_drop", {31'd0, uop_valid}, 32'd0);
        chk("t2_in_ready_back", {31'd0, in_ready}, 32'd1);
        send(32'hB000_0000);
        chk("t2_frag_done", {31'd0, frag_done}, 32'd1);
        chk("t2_frag_count", {25'd0, frag_count}, 32'd1);
        chk("t2_active_off", {31'd0, frag_active}, 32'd0);
        chk("t2_no_err", {31'd0, err}, 32'd0);
        tick();
        chk("t2_done_pulse", {31'd0, frag_done}, 32'd0);

        // Prefix merge, then backpressure
        uop_ready = 1'b0;
        send(32'hA000_0003);
        send(32'h8000_0005);
        send(32'h6000_AAFC);
        send(32'h2B32_95C7);
        chk("t3_uop_valid", {31'd0, uop_valid}, 32'd1);
        chk("t3_immhi", {6'd0, uop_immhi}, 32'h5);
        chk("t3_tgt", {16'd0, uop_tgt}, 32'hAAFC);
        chk("t3_immhi_vld", {31'd0, uop_immhi_vld}, 32'd1);
        chk("t3_tgt_vld", {31'd0, uop_tgt_vld}, 32'd1);
        chk("t3_word", uop_word, 32'h2B32_95C7);
        for (int i = 0; i < 5; i++) begin
            tick();
            held = uop_word;
            chk("t4_hold_valid", {31'd0, uop_valid}, 32'd1);
            chk("t4_hold_word", held, 32'h2B32_95C7);
            chk("t4_hold_idx", {26'd0, uop_idx}, 32'd0);
            chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
        end
        uop_ready = 1'b1;
        tick();
        chk("t4_release", {31'd0, uop_valid}, 32'd0);
        chk("t4_ready_back", {31'd0, in_ready}, 32'd1);
        send(32'h0000_0002);
        chk("t4_idx_inc", {26'd0, uop_idx}, 32'd1);
        chk("t4_immhi_clr", {31'd0, uop_immhi_vld}, 32'd0);
        chk("t4_tgt_clr", {31'd0, uop_tgt_vld}, 32'd0);
        tick();
        chk("t4_once", {31'd0, uop_valid}, 32'd0);
        send(32'hB000_0000);
        chk("t4_frag_count", {25'd0, frag_count}, 32'd2);

        // Error cases
        send(32'h0000_0001);
        chk("t5_idle_err", {31'd0, err}, 32'd1);
        chk("t5_idle_code", {30'd0, err_code}, 32'd1);
        chk("t5_idle_inactive", {31'd0, frag_active}, 32'd0);
        send(32'hA000_0003);
        chk("t5_start_no_err", {31'd0, err}, 32'd0);
        send(32'hFFFF_FFFF);
        chk("t5_inv_err", {31'd0, err}, 32'd1);
        chk("t5_inv_code", {30'd0, err_code}, 32'd3);
        chk("t5_inv_active", {31'd0, frag_active}, 32'd1);
        send(32'h8000_0001);
        chk("t5_i1_no_err", {31'd0, err}, 32'd0);
        send(32'h8000_0002);
        chk("t5_dup_err", {31'd0, err}, 32'd1);
        chk("t5_dup_code", {30'd0, err_code}, 32'd2);
        send(32'hB000_0000);
        chk("t5_dangling_err", {31'd0, err}, 32'd1);
        chk("t5_dangling_code", {30'd0, err_code}, 32'd2);
        chk("t5_done", {31'd0, frag_done}, 32'd1);
        chk("t5_count0", {25'd0, frag_count}, 32'd0);
        tick();
        chk("t5_err_pulse", {31'd0, err}, 32'd0);

        // Overflow past nalloc
        send(32'hA000_0002);
        for (int i = 0; i < 4; i++) begin
            send(32'h0000_0010 + i);
            chk("t6_valid", {31'd0, uop_valid}, 32'd1);
            chk("t6_idx", {26'd0, uop_idx}, i);
            chk("t6_err", {31'd0, err}, (i >= 2) ? 32'd1 : 32'd0);
            chk("t6_code", {30'd0, err_code}, (i >= 2) ? 32'd1 : 32'd0);
            tick();
        end
        send(32'hB000_0000);
        chk("t6_done", {31'd0, frag_done}, 32'd1);
        chk("t6_count", {25'd0, frag_count}, 32'd4);

        // Reset while a micro-op is pending
        uop_ready = 1'b0;
        send(32'hA000_0003);
        send(32'h0000_0007);
        chk("t1_pre_valid", {31'd0, uop_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_uop_valid", {31'd0, uop_valid}, 32'd0);
        chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t1_active", {31'd0, frag_active}, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        send(32'hA000_0001);
        chk("t1_restart", {31'd0, frag_active}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
